// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, a FIFO_DEPTH-entry byte queue feeding an 8N1 serialiser.
// Optional macro UART_TX_PARITY_EN inserts an even-parity symbol before the stop bit (8E1 frames).
module uart_tx_fifo #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [7:0]                      data_in,
   input  logic                            data_in_valid,
   output logic                            data_in_ready,
   output logic                            serial_out,
   output logic                            tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int BAUD_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
   localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(SYMBOL_EDGE_TIME - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd3
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              serial_q, serial_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              push_s, pop_s, sym_end_s;

`ifdef UART_TX_PARITY_EN
   function automatic logic even_parity(input logic [7:0] b);
      even_parity = ^b;
   endfunction
`endif

   // Handshake and pop decision; ready comes from a flop so valid never reaches it.
   always_comb begin
      sym_end_s = (baud_q == BAUD_MAX);
      push_s    = data_in_valid && ready_q;
      pop_s     = 1'b0;
      if (count_q != CNT_W'(0)) begin
         if (state_q == S_IDLE) begin
            pop_s = 1'b1;
         end else if ((state_q == S_STOP) && sym_end_s) begin
            pop_s = 1'b1;
         end else begin
            pop_s = 1'b0;
         end
      end else begin
         pop_s = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (pop_s) state_d = S_START;
            else       state_d = S_IDLE;
         end
         S_START: begin
            if (sym_end_s) state_d = S_DATA;
            else           state_d = S_START;
         end
         S_DATA: begin
            if (sym_end_s && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end else begin
               state_d = S_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (sym_end_s) state_d = S_STOP;
            else           state_d = S_PARITY;
         end
`endif
         S_STOP: begin
            if (sym_end_s && pop_s)  state_d = S_START;
            else if (sym_end_s)      state_d = S_IDLE;
            else                     state_d = S_STOP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM output: line level for the next cycle, registered below.
   always_comb begin
      serial_d = 1'b1;
      case (state_q)
         S_IDLE:   serial_d = 1'b1;
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = shift_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
         S_PARITY: serial_d = even_parity(shift_q);
`endif
         S_STOP:   serial_d = 1'b1;
         default:  serial_d = 1'b1;
      endcase
   end

   // Datapath next state: FIFO bookkeeping, baud timing, bit index, shift register.
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if ((state_q == S_IDLE) || sym_end_s) begin
         baud_d = BAUD_W'(0);
      end else begin
         baud_d = baud_q + BAUD_W'(1);
      end
      if (state_q != S_DATA) begin
         bit_idx_d = 3'd0;
      end else if (sym_end_s) begin
         bit_idx_d = bit_idx_q + 3'd1;
      end else begin
         bit_idx_d = bit_idx_q;
      end
      shift_d = pop_s ? mem_q[rd_ptr_q] : shift_q;
      ready_d = (count_d < CNT_FULL);
      busy_d  = (state_d != S_IDLE) || (count_d != CNT_W'(0));
   end

   // Datapath registers; reset also aborts any frame in flight and flushes the queue.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= PTR_W'(0);
         rd_ptr_q  <= PTR_W'(0);
         count_q   <= CNT_W'(0);
         baud_q    <= BAUD_W'(0);
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         serial_q  <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         serial_q  <= serial_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   // FIFO storage, written on an accepted push.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   assign data_in_ready = ready_q;
   assign serial_out    = serial_q;
   assign tx_busy       = busy_q;
   assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of pushed bytes checked by a serial receiver model.
module tb_uart_tx_fifo;

   localparam int TB_CLK  = 1_300_000;
   localparam int TB_BAUD = 100_000;
   localparam int BIT     = TB_CLK / TB_BAUD;
   localparam int DEPTH   = 8;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME   = 11;
`else
   localparam int FRAME   = 10;
`endif

   logic       clk           = 1'b0;
   logic       reset         = 1'b1;
   logic [7:0] data_in       = 8'h00;
   logic       data_in_valid = 1'b0;
   logic       data_in_ready;
   logic       serial_out;
   logic       tx_busy;
   logic [3:0] fifo_count;

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   logic rx_enable   = 1'b0;
   logic rx_active   = 1'b0;
   logic [7:0] exp_q[$];
   int   start_times[$];

   uart_tx_fifo #(
      .CLOCK_FREQ(TB_CLK),
      .BAUD_RATE (TB_BAUD),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready),
      .serial_out   (serial_out),
      .tx_busy      (tx_busy),
      .fifo_count   (fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Receiver model: decodes frames mid-symbol and pops the scoreboard.
   initial begin : rx_model
      logic [7:0] got;
      logic [7:0] exp_b;
      forever begin
         @(negedge clk);
         if (rx_enable && (serial_out === 1'b0)) begin
            rx_active = 1'b1;
            start_times.push_back(cyc);
            repeat (BIT / 2) @(negedge clk);
            vectors++;
            if (serial_out !== 1'b0) begin
               miscompares++;
               $display("FAIL rx_start: got %b expected 0", serial_out);
            end
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               got[i] = serial_out;
            end
`ifdef UART_TX_PARITY_EN
            repeat (BIT) @(negedge clk);
            vectors++;
            if (serial_out !== ^got) begin
               miscompares++;
               $display("FAIL rx_parity: got %b expected %b", serial_out, ^got);
            end
`endif
            repeat (BIT) @(negedge clk);
            vectors++;
            if (serial_out !== 1'b1) begin
               miscompares++;
               $display("FAIL rx_stop: got %b expected 1", serial_out);
            end
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL rx_unexpected: got byte %h expected none", got);
            end else begin
               exp_b = exp_q.pop_front();
               if (got !== exp_b) begin
                  miscompares++;
                  $display("FAIL rx_byte: got %h expected %h", got, exp_b);
               end
            end
            rx_active = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves data_in_valid high so consecutive calls push on consecutive edges.
   task automatic push_byte(input logic [7:0] b);
      int n = 0;
      data_in       = b;
      data_in_valid = 1'b1;
      while ((data_in_ready !== 1'b1) && (n < 4 * FRAME * BIT)) begin
         tick();
         n++;
      end
      vectors++;
      if (data_in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL push_timeout: got ready %b expected 1 for byte %h", data_in_ready, b);
      end else begin
         exp_q.push_back(b);
      end
      tick();
   endtask

   task automatic stop_push();
      data_in_valid = 1'b0;
   endtask

   task automatic wait_rx_done(input int limit);
      int n = 0;
      while (((exp_q.size() != 0) || rx_active) && (n < limit)) begin
         tick();
         n++;
      end
      vectors++;
      if ((exp_q.size() != 0) || rx_active) begin
         miscompares++;
         $display("FAIL rx_done_timeout: got %0d pending expected 0", exp_q.size());
      end
      repeat (BIT) tick();
   endtask

   task automatic test_reset();
      int lows = 0;
      reset = 1'b1;
      data_in_valid = 1'b0;
      repeat (5) tick();
      reset = 1'b0;
      tick();
      vectors++;
      if ({serial_out, data_in_ready, tx_busy, fifo_count} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
         miscompares++;
         $display("FAIL reset_state: got ser=%b rdy=%b busy=%b cnt=%0d expected 1 1 0 0",
                  serial_out, data_in_ready, tx_busy, fifo_count);
      end
      for (int i = 0; i < 20000; i++) begin
         tick();
         if (serial_out !== 1'b1) lows++;
      end
      vectors++;
      if (lows != 0) begin
         miscompares++;
         $display("FAIL idle_line: got %0d low cycles expected 0", lows);
      end
   endtask

   task automatic test_single();
      logic [7:0]       b = 8'h55;
      logic [FRAME-1:0] sym;
      int               t = 0;
      sym    = '1;
      sym[0] = 1'b0;
      for (int i = 0; i < 8; i++) sym[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
      sym[9] = ^b;
`endif
      rx_enable = 1'b1;
      push_byte(b);
      stop_push();
      vectors++;
      if ({fifo_count, serial_out, tx_busy} !== {4'd1, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL single_after_push: got cnt=%0d ser=%b busy=%b expected 1 1 1",
                  fifo_count, serial_out, tx_busy);
      end
      tick();
      vectors++;
      if ({fifo_count, serial_out} !== {4'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL single_pop_edge: got cnt=%0d ser=%b expected 0 1", fifo_count, serial_out);
      end
      tick();
      vectors++;
      if (serial_out !== 1'b0) begin
         miscompares++;
         $display("FAIL single_start_edge: got %b expected 0", serial_out);
      end
      for (int k = 0; k < FRAME; k++) begin
         while (t < BIT / 2 + k * BIT) begin
            tick();
            t++;
         end
         vectors++;
         if (serial_out !== sym[k]) begin
            miscompares++;
            $display("FAIL single_symbol_%0d: got %b expected %b", k, serial_out, sym[k]);
         end
      end
      while (t < FRAME * BIT - 2) begin
         tick();
         t++;
      end
      vectors++;
      if (tx_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_busy_late: got %b expected 1", tx_busy);
      end
      while (t < FRAME * BIT) begin
         tick();
         t++;
      end
      vectors++;
      if ({tx_busy, serial_out} !== {1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL single_busy_end: got busy=%b ser=%b expected 0 1", tx_busy, serial_out);
      end
      wait_rx_done(4 * FRAME * BIT);
   endtask

   task automatic test_back_to_back();
      start_times.delete();
      push_byte(8'hA3);
      push_byte(8'h00);
      push_byte(8'hFF);
      stop_push();
      wait_rx_done(6 * FRAME * BIT);
      vectors++;
      if (start_times.size() != 3) begin
         miscompares++;
         $display("FAIL burst_frames: got %0d expected 3", start_times.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            vectors++;
            if (start_times[i] - start_times[i - 1] != FRAME * BIT) begin
               miscompares++;
               $display("FAIL burst_gap_%0d: got %0d expected %0d", i,
                        start_times[i] - start_times[i - 1], FRAME * BIT);
            end
         end
      end
   endtask

   task automatic test_full();
      for (int i = 1; i <= 9; i++) push_byte(8'(i));
      vectors++;
      if ({fifo_count, data_in_ready} !== {4'd8, 1'b0}) begin
         miscompares++;
         $display("FAIL full_state: got cnt=%0d rdy=%b expected 8 0", fifo_count, data_in_ready);
      end
      push_byte(8'd10);
      stop_push();
      wait_rx_done(14 * FRAME * BIT);
   endtask

   task automatic test_simul_push_pop();
      int c0;
      push_byte(8'h11);
      c0 = cyc;
      push_byte(8'h22);
      push_byte(8'h33);
      push_byte(8'h44);
      stop_push();
      while (cyc < c0 + FRAME * BIT) tick();
      vectors++;
      if ({fifo_count, serial_out} !== {4'd3, 1'b1}) begin
         miscompares++;
         $display("FAIL simul_before: got cnt=%0d ser=%b expected 3 1", fifo_count, serial_out);
      end
      data_in       = 8'h55;
      data_in_valid = 1'b1;
      exp_q.push_back(8'h55);
      tick();
      stop_push();
      vectors++;
      if (fifo_count !== 4'd3) begin
         miscompares++;
         $display("FAIL simul_count: got %0d expected 3", fifo_count);
      end
      wait_rx_done(8 * FRAME * BIT);
   endtask

   task automatic test_reset_mid_frame();
      int lows = 0;
      rx_enable = 1'b0;
      push_byte(8'h0F);
      push_byte(8'hC1);
      push_byte(8'h7E);
      stop_push();
      repeat (5 * BIT + BIT / 2) tick();
      vectors++;
      if ({serial_out, fifo_count} !== {1'b0, 4'd2}) begin
         miscompares++;
         $display("FAIL mid_bit4: got ser=%b cnt=%0d expected 0 2", serial_out, fifo_count);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      vectors++;
      if ({serial_out, fifo_count, tx_busy, data_in_ready} !== {1'b1, 4'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL mid_reset_state: got ser=%b cnt=%0d busy=%b rdy=%b expected 1 0 0 1",
                  serial_out, fifo_count, tx_busy, data_in_ready);
      end
      for (int i = 0; i < 3 * FRAME * BIT; i++) begin
         tick();
         if (serial_out !== 1'b1) lows++;
      end
      vectors++;
      if (lows != 0) begin
         miscompares++;
         $display("FAIL mid_no_resend: got %0d low cycles expected 0", lows);
      end
      rx_enable = 1'b1;
      push_byte(8'h96);
      stop_push();
      wait_rx_done(4 * FRAME * BIT);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_simul_push_pop();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
